// File: rtl/wishbone_skid_fifo_pkg.sv
// rtl/wishbone_skid_fifo_pkg.sv - shared types and width helpers for the Wishbone skid FIFO
package wishbone_skid_fifo_pkg;

    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_CONST   = 3'b001,
        CTI_INCR    = 3'b010,
        CTI_EOB     = 3'b111
    } cti_t;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_SEL_W  = 4;

    // Field order of a stored request, MSB first; the top packs vectors in this same order.
    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] adr;
        logic [DEF_DATA_W-1:0] dat;
        logic [DEF_SEL_W-1:0]  sel;
    } wb_req_t;

    function automatic int req_width(input int addr_w, input int data_w, input int sel_w);
        return 1 + addr_w + data_w + sel_w;
    endfunction

    // One extra pointer bit distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wishbone_skid_fifo_if.sv
// rtl/wishbone_skid_fifo_if.sv - pipelined Wishbone bus bundle with master/slave views
interface wishbone_skid_fifo_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_w;
    logic [SEL_W-1:0]  sel;
    logic              stall;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] dat_r;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  stall, ack, err, dat_r
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output stall, ack, err, dat_r
    );
endinterface

// File: rtl/wishbone_sync_fifo.sv
// rtl/wishbone_sync_fifo.sv - generic DEPTH x W synchronous FIFO with flush
module wishbone_sync_fifo
    import wishbone_skid_fifo_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int W     = 53,
    localparam int PW    = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] level
);
    localparam int AW = PW - 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push;
    logic          do_pop;

    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == PW'(DEPTH));
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/wishbone_skid_fifo.sv
// rtl/wishbone_skid_fifo.sv - Wishbone B4 pipelined request buffer with registered initiator stall
// Optional target-side output register stage: define WB_SKID_FIFO_OREG_EN.
module wishbone_skid_fifo
    import wishbone_skid_fifo_pkg::*;
#(
    parameter  int ADDR_W    = 16,
    parameter  int DATA_W    = 32,
    parameter  int GRAN      = 8,
    parameter  int DEPTH     = 4,
    parameter  int MAX_OUTST = 4,
    localparam int SEL_W     = DATA_W / GRAN,
    localparam int LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wishbone_skid_fifo_if.slave  i_bus,
    wishbone_skid_fifo_if.master t_bus,
    output logic [LVL_W-1:0]     level
);
    localparam int REQ_W = req_width(ADDR_W, DATA_W, SEL_W);
    localparam int OW    = $clog2(MAX_OUTST + 1);
`ifdef WB_SKID_FIFO_OREG_EN
    localparam int CAP   = DEPTH + 1;
`else
    localparam int CAP   = DEPTH;
`endif

    logic             stall_q, stall_d;
    logic [OW-1:0]    outst_q, outst_d;
    logic [LVL_W-1:0] level_d;

    logic             flush;
    logic             push;
    logic             issue;
    logic             resp;
    logic             room;
    logic             req_avail;
    logic             t_stb_w;
    logic [REQ_W-1:0] push_req;
    logic [REQ_W-1:0] head_req;
    logic [REQ_W-1:0] out_req;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;

    assign flush    = ~i_bus.cyc;
    assign push     = i_bus.cyc & i_bus.stb & ~stall_q & ~fifo_full;
    assign push_req = {i_bus.we, i_bus.adr, i_bus.dat_w, i_bus.sel};
    assign room     = (outst_q < OW'(MAX_OUTST));
    assign resp     = (t_bus.ack | t_bus.err) & (outst_q != '0);
    assign t_stb_w  = i_bus.cyc & req_avail & room;
    assign issue    = t_stb_w & ~t_bus.stall;

    wishbone_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (fifo_pop),
        .flush (flush),
        .wdata (push_req),
        .rdata (head_req),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef WB_SKID_FIFO_OREG_EN
    logic             oreg_vld_q, oreg_vld_d;
    logic [REQ_W-1:0] oreg_q, oreg_d;
    logic             load;

    // Refill only when the stage is free or its entry leaves this cycle.
    assign load      = i_bus.cyc & ~fifo_empty & (~oreg_vld_q | issue);
    assign fifo_pop  = load;
    assign req_avail = oreg_vld_q;
    assign out_req   = oreg_q;
    assign level     = fifo_level + LVL_W'(oreg_vld_q);

    always_comb begin
        oreg_vld_d = oreg_vld_q;
        oreg_d     = oreg_q;
        if (flush) begin
            oreg_vld_d = 1'b0;
            oreg_d     = '0;
        end else if (load) begin
            oreg_vld_d = 1'b1;
            oreg_d     = head_req;
        end else if (issue) begin
            oreg_vld_d = 1'b0;
            oreg_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg_vld_q <= 1'b0;
            oreg_q     <= '0;
        end else begin
            oreg_vld_q <= oreg_vld_d;
            oreg_q     <= oreg_d;
        end
    end
`else
    assign fifo_pop  = issue;
    assign req_avail = ~fifo_empty;
    assign out_req   = head_req;
    assign level     = fifo_level;
`endif

    always_comb begin
        level_d = level + LVL_W'(push) - LVL_W'(issue);
        stall_d = flush ? 1'b0 : (level_d == LVL_W'(CAP));
    end

    // Issue and response in the same cycle cancel out.
    always_comb begin
        outst_d = outst_q;
        if (flush) begin
            outst_d = '0;
        end else if (issue && !resp) begin
            outst_d = outst_q + OW'(1);
        end else if (resp && !issue) begin
            outst_d = outst_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
            outst_q <= '0;
        end else begin
            stall_q <= stall_d;
            outst_q <= outst_d;
        end
    end

    assign t_bus.cyc = i_bus.cyc & ((level != '0) | (outst_q != '0) | i_bus.stb);
    assign t_bus.stb = t_stb_w;
    assign {t_bus.we, t_bus.adr, t_bus.dat_w, t_bus.sel} = t_stb_w ? out_req : '0;

    assign i_bus.stall = stall_q;
    assign i_bus.ack   = t_bus.ack & i_bus.cyc & (outst_q != '0);
    assign i_bus.err   = t_bus.err & i_bus.cyc & (outst_q != '0);
    assign i_bus.dat_r = t_bus.dat_r;

endmodule
